// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Round-robin arbiter sharing one main-memory port between two
//               cache-side requesters, one transaction at a time.
//               Optional ack timeout enabled by MEM_ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  busy,
    output logic                  arb_timeout,

    input  logic                  req0_valid,
    input  logic                  req0_write,
    input  logic [ADDR_WIDTH-1:0] req0_address,
    input  logic [DATA_WIDTH-1:0] req0_write_data,
    output logic                  req0_ready,
    output logic [DATA_WIDTH-1:0] req0_read_data,

    input  logic                  req1_valid,
    input  logic                  req1_write,
    input  logic [ADDR_WIDTH-1:0] req1_address,
    input  logic [DATA_WIDTH-1:0] req1_write_data,
    output logic                  req1_ready,
    output logic [DATA_WIDTH-1:0] req1_read_data,

    output logic                  mem_valid,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_write_enable,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    input  logic [DATA_WIDTH-1:0] mem_read_data,
    input  logic                  mem_ack
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_busy = 2'd1;
    localparam logic [1:0] c_st_resp = 2'd2;

    logic [1:0]            r_state;
    logic                  r_owner;
    logic                  r_last_grant;
    logic                  r_write;
    logic                  r_timeout;
    logic [1:0]            r_ready;
    logic [ADDR_WIDTH-1:0] r_address;
    logic [DATA_WIDTH-1:0] r_write_data;
    logic [DATA_WIDTH-1:0] r_read_data0;
    logic [DATA_WIDTH-1:0] r_read_data1;
    logic                  w_grant;
    logic                  w_timeout;

    // On a tie the port that did not win last time gets the memory
    always_comb begin
        w_grant = 1'b0;
        if (req0_valid && req1_valid) begin
            w_grant = ~r_last_grant;
        end else if (req1_valid) begin
            w_grant = 1'b1;
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int c_cnt_w = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [c_cnt_w-1:0] c_limit = c_cnt_w'(TIMEOUT_CYCLES - 1);

    logic [c_cnt_w-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (r_state != c_st_busy) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    // Count holds the number of BUSY cycles already elapsed
    assign w_timeout = (r_state == c_st_busy) && (r_count == c_limit);
`else
    wire w_unused_timeout = (TIMEOUT_CYCLES != 0);
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_st_idle;
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;
            r_write      <= 1'b0;
            r_timeout    <= 1'b0;
            r_ready      <= 2'b00;
            r_address    <= '0;
            r_write_data <= '0;
            r_read_data0 <= '0;
            r_read_data1 <= '0;
        end else begin
            r_ready   <= 2'b00;
            r_timeout <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (req0_valid || req1_valid) begin
                        r_owner      <= w_grant;
                        r_write      <= w_grant ? req1_write      : req0_write;
                        r_address    <= w_grant ? req1_address    : req0_address;
                        r_write_data <= w_grant ? req1_write_data : req0_write_data;
                        r_state      <= c_st_busy;
                    end
                end
                c_st_busy: begin
                    if (mem_ack) begin
                        if (!r_write) begin
                            if (r_owner) r_read_data1 <= mem_read_data;
                            else         r_read_data0 <= mem_read_data;
                        end
                        r_last_grant     <= r_owner;
                        r_ready[r_owner] <= 1'b1;
                        r_state          <= c_st_resp;
                    end else if (w_timeout) begin
                        if (!r_write) begin
                            if (r_owner) r_read_data1 <= '0;
                            else         r_read_data0 <= '0;
                        end
                        r_last_grant     <= r_owner;
                        r_ready[r_owner] <= 1'b1;
                        r_timeout        <= 1'b1;
                        r_state          <= c_st_resp;
                    end
                end
                c_st_resp: begin
                    r_state <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign busy             = (r_state != c_st_idle);
    assign mem_valid        = (r_state == c_st_busy);
    assign mem_write_enable = mem_valid & r_write;
    assign mem_address      = r_address;
    assign mem_write_data   = r_write_data;
    assign req0_ready       = r_ready[0];
    assign req1_ready       = r_ready[1];
    assign req0_read_data   = r_read_data0;
    assign req1_read_data   = r_read_data1;
    assign arb_timeout      = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter: directed scenarios plus a
//               randomized run against a transaction-level reference model.
//               The timeout scenario runs when MEM_ARB_TIMEOUT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mem_arbiter;

    localparam int c_aw = 32;
    localparam int c_dw = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            busy, arb_timeout;
    logic            req0_valid, req0_write, req0_ready;
    logic [c_aw-1:0] req0_address;
    logic [c_dw-1:0] req0_write_data, req0_read_data;
    logic            req1_valid, req1_write, req1_ready;
    logic [c_aw-1:0] req1_address;
    logic [c_dw-1:0] req1_write_data, req1_read_data;
    logic            mem_valid, mem_write_enable, mem_ack;
    logic [c_aw-1:0] mem_address;
    logic [c_dw-1:0] mem_write_data, mem_read_data;

    int n_pass  = 0;
    int n_total = 0;
    logic [c_dw-1:0] exp_rd1;

    always #5 clk = ~clk;

    mem_arbiter #(
        .ADDR_WIDTH     (c_aw),
        .DATA_WIDTH     (c_dw),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .busy             (busy),
        .arb_timeout      (arb_timeout),
        .req0_valid       (req0_valid),
        .req0_write       (req0_write),
        .req0_address     (req0_address),
        .req0_write_data  (req0_write_data),
        .req0_ready       (req0_ready),
        .req0_read_data   (req0_read_data),
        .req1_valid       (req1_valid),
        .req1_write       (req1_write),
        .req1_address     (req1_address),
        .req1_write_data  (req1_write_data),
        .req1_ready       (req1_ready),
        .req1_read_data   (req1_read_data),
        .mem_valid        (mem_valid),
        .mem_address      (mem_address),
        .mem_write_enable (mem_write_enable),
        .mem_write_data   (mem_write_data),
        .mem_read_data    (mem_read_data),
        .mem_ack          (mem_ack)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req0_valid = 0; req0_write = 0; req0_address = '0; req0_write_data = '0;
        req1_valid = 0; req1_write = 0; req1_address = '0; req1_write_data = '0;
        mem_ack = 0; mem_read_data = '0;
    endtask

    task automatic apply_reset();
        rst_n = 0;
        clear_inputs();
        step();
        step();
        rst_n = 1;
        step();
    endtask

    task automatic test_reset();
        rst_n = 0;
        clear_inputs();
        step();
        step();
        n_total++;
        if ({busy, mem_valid, mem_write_enable, req0_ready, req1_ready, arb_timeout} !== 6'b0)
            $display("FAIL reset_ctrl: got %b required 000000",
                     {busy, mem_valid, mem_write_enable, req0_ready, req1_ready, arb_timeout});
        else n_pass++;
        n_total++;
        if (mem_address !== '0 || mem_write_data !== '0)
            $display("FAIL reset_mem_bus: got addr %h wdata %h required 0", mem_address, mem_write_data);
        else n_pass++;
        n_total++;
        if (req0_read_data !== '0 || req1_read_data !== '0)
            $display("FAIL reset_read_data: got %h %h required 0", req0_read_data, req1_read_data);
        else n_pass++;
        rst_n = 1;
        step();
    endtask

    task automatic test_single_read();
        int busy_cycles = 0, rdy0 = 0, rdy1 = 0, bad = 0;
        req0_valid = 1; req0_write = 0; req0_address = 32'h0000_1000; req0_write_data = 32'h1;
        step();
        n_total++;
        if (mem_valid !== 1'b1) $display("FAIL read_latency: mem_valid got %b required 1", mem_valid);
        else n_pass++;
        for (int cyc = 0; cyc < 12; cyc++) begin
            mem_ack = 0;
            if (mem_valid) begin
                busy_cycles++;
                if (mem_address !== 32'h0000_1000 || mem_write_enable !== 1'b0) bad++;
                if (busy_cycles == 3) begin mem_ack = 1; mem_read_data = 32'hCAFE_F00D; end
            end
            if (req0_ready) begin rdy0++; req0_valid = 0; end
            if (req1_ready) rdy1++;
            step();
        end
        n_total++;
        if (busy_cycles != 3 || bad != 0)
            $display("FAIL read_busy: got %0d cycles %0d bad, required 3 cycles 0 bad", busy_cycles, bad);
        else n_pass++;
        n_total++;
        if (rdy0 != 1 || rdy1 != 0)
            $display("FAIL read_ready: got r0=%0d r1=%0d required 1 and 0", rdy0, rdy1);
        else n_pass++;
        n_total++;
        if (req0_read_data !== 32'hCAFE_F00D)
            $display("FAIL read_data: got %h required cafef00d", req0_read_data);
        else n_pass++;
    endtask

    task automatic test_simultaneous();
        int order[4];
        int n_done = 0, overlap = 0, bad_data = 0;
        apply_reset();
        req0_valid = 1; req0_write = 0; req0_address = 32'h0000_A000;
        req1_valid = 1; req1_write = 0; req1_address = 32'h0000_B000;
        for (int cyc = 0; cyc < 60 && n_done < 4; cyc++) begin
            if (req0_ready && req1_ready) overlap++;
            if (req0_ready) begin
                order[n_done] = 0; n_done++;
                if (req0_read_data !== (32'h0000_A000 ^ 32'h5555)) bad_data++;
            end else if (req1_ready) begin
                order[n_done] = 1; n_done++;
                if (req1_read_data !== (32'h0000_B000 ^ 32'h5555)) bad_data++;
            end
            mem_ack = mem_valid;
            mem_read_data = mem_address ^ 32'h5555;
            step();
        end
        req0_valid = 0; req1_valid = 0; mem_ack = 0;
        step(); step();
        n_total++;
        if (n_done != 4) $display("FAIL simul_count: got %0d completions required 4", n_done);
        else n_pass++;
        n_total++;
        if (n_done == 4 && {order[0] != 0, order[1] != 1, order[2] != 0, order[3] != 1} != 4'b0)
            $display("FAIL simul_order: got %0d%0d%0d%0d required 0101", order[0], order[1], order[2], order[3]);
        else if (n_done == 4) n_pass++;
        else $display("FAIL simul_order: got only %0d grants required 0101", n_done);
        n_total++;
        if (overlap != 0 || bad_data != 0)
            $display("FAIL simul_ready: got overlap %0d bad data %0d required 0 and 0", overlap, bad_data);
        else n_pass++;
        exp_rd1 = 32'h0000_B000 ^ 32'h5555;
    endtask

    task automatic test_write();
        int busy_cycles = 0, rdy1 = 0, bad = 0;
        req1_valid = 1; req1_write = 1; req1_address = 32'h0000_2040; req1_write_data = 32'h1234_5678;
        for (int cyc = 0; cyc < 12; cyc++) begin
            mem_ack = 0;
            if (mem_valid) begin
                busy_cycles++;
                if (mem_write_enable !== 1'b1 || mem_write_data !== 32'h1234_5678 ||
                    mem_address !== 32'h0000_2040) bad++;
                if (busy_cycles == 2) begin mem_ack = 1; mem_read_data = 32'hDEAD_BEEF; end
            end
            if (req1_ready) begin rdy1++; req1_valid = 0; end
            step();
        end
        n_total++;
        if (busy_cycles != 2 || bad != 0)
            $display("FAIL write_bus: got %0d cycles %0d bad, required 2 cycles 0 bad", busy_cycles, bad);
        else n_pass++;
        n_total++;
        if (rdy1 != 1) $display("FAIL write_ready: got %0d pulses required 1", rdy1);
        else n_pass++;
        n_total++;
        if (req1_read_data !== exp_rd1)
            $display("FAIL write_keeps_data: got %h required %h", req1_read_data, exp_rd1);
        else n_pass++;
    endtask

    task automatic test_spurious_and_drop();
        int busy_seen = 0, rdy = 0, busy_cycles = 0;
        clear_inputs();
        for (int cyc = 0; cyc < 3; cyc++) begin
            mem_ack = 1; mem_read_data = 32'h7777_7777;
            step();
            if (req0_ready || req1_ready) rdy++;
            if (busy) busy_seen++;
        end
        mem_ack = 0;
        n_total++;
        if (rdy != 0 || busy_seen != 0)
            $display("FAIL spurious_ack: got ready %0d busy %0d required 0 and 0", rdy, busy_seen);
        else n_pass++;
        req0_valid = 1; req0_write = 0; req0_address = 32'h0000_3000;
        for (int cyc = 0; cyc < 12; cyc++) begin
            mem_ack = 0;
            if (mem_valid) begin
                busy_cycles++;
                if (busy_cycles == 1) req0_valid = 0;
                if (busy_cycles == 3) begin mem_ack = 1; mem_read_data = 32'h0BAD_F00D; end
            end else if (busy) begin
                mem_ack = 1; mem_read_data = 32'h9999_9999;
            end
            if (req0_ready) rdy++;
            step();
        end
        n_total++;
        if (rdy != 1) $display("FAIL drop_ready: got %0d pulses required 1", rdy);
        else n_pass++;
        n_total++;
        if (req0_read_data !== 32'h0BAD_F00D)
            $display("FAIL drop_data: got %h required 0badf00d", req0_read_data);
        else n_pass++;
    endtask

    task automatic test_reset_busy();
        int rdy = 0, busy_seen = 0;
        clear_inputs();
        req1_valid = 1; req1_address = 32'h0000_4000;
        step(); step();
        rst_n = 0;
        #1;
        n_total++;
        if ({busy, mem_valid, req0_ready, req1_ready} !== 4'b0 || mem_address !== '0 ||
            req0_read_data !== '0 || req1_read_data !== '0)
            $display("FAIL reset_busy_outputs: got busy %b valid %b addr %h rd %h %h required all 0",
                     busy, mem_valid, mem_address, req0_read_data, req1_read_data);
        else n_pass++;
        req1_valid = 0;
        step();
        rst_n = 1;
        mem_ack = 1; mem_read_data = 32'h5A5A_5A5A;
        step();
        mem_ack = 0;
        for (int cyc = 0; cyc < 4; cyc++) begin
            if (req0_ready || req1_ready) rdy++;
            if (busy) busy_seen++;
            step();
        end
        n_total++;
        if (rdy != 0 || busy_seen != 0)
            $display("FAIL late_ack: got ready %0d busy %0d required 0 and 0", rdy, busy_seen);
        else n_pass++;
        req1_valid = 1; req1_address = 32'h0000_4004;
        for (int cyc = 0; cyc < 10; cyc++) begin
            mem_ack = mem_valid; mem_read_data = 32'h0000_600D;
            if (req1_ready) begin rdy++; req1_valid = 0; end
            step();
        end
        mem_ack = 0;
        n_total++;
        if (rdy != 1 || req1_read_data !== 32'h0000_600D)
            $display("FAIL after_reset_txn: got %0d pulses data %h required 1 and 0000600d", rdy, req1_read_data);
        else n_pass++;
    endtask

`ifdef MEM_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int busy_cycles = 0, pulses = 0, together = 0;
        apply_reset();
        req0_valid = 1; req0_address = 32'h0000_5000;
        for (int cyc = 0; cyc < 8; cyc++) begin
            mem_ack = mem_valid; mem_read_data = 32'h1111_1111;
            if (req0_ready) req0_valid = 0;
            step();
        end
        mem_ack = 0; mem_read_data = 32'hFFFF_FFFF;
        n_total++;
        if (req0_read_data !== 32'h1111_1111)
            $display("FAIL timeout_pre: got %h required 11111111", req0_read_data);
        else n_pass++;
        req0_valid = 1; req0_address = 32'h0000_5004;
        for (int cyc = 0; cyc < 14; cyc++) begin
            if (mem_valid) busy_cycles++;
            if (arb_timeout) pulses++;
            if (arb_timeout && req0_ready) together++;
            if (req0_ready) req0_valid = 0;
            step();
        end
        n_total++;
        if (busy_cycles != 4 || pulses != 1 || together != 1)
            $display("FAIL timeout_pulse: got busy %0d pulses %0d together %0d required 4 1 1",
                     busy_cycles, pulses, together);
        else n_pass++;
        n_total++;
        if (req0_read_data !== '0) $display("FAIL timeout_data: got %h required 0", req0_read_data);
        else n_pass++;
    endtask
`endif

    task automatic test_random();
        bit              pend[2], wr[2], exp_rdy[2];
        logic [c_aw-1:0] ad[2];
        logic [c_dw-1:0] wd[2], exp_rd[2];
        int              phase, owner, last, lat, bcnt;
        bit              m_wr, ack;
        logic [c_aw-1:0] m_ad;
        logic [c_dw-1:0] m_wd, rdat;
        apply_reset();
        pend = '{1'b0, 1'b0}; wr = '{1'b0, 1'b0}; exp_rdy = '{1'b0, 1'b0};
        ad = '{32'h0, 32'h0}; wd = '{32'h0, 32'h0}; exp_rd = '{32'h0, 32'h0};
        phase = 0; owner = 0; last = 1; lat = 1; bcnt = 0;
        m_wr = 0; m_ad = '0; m_wd = '0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            n_total++;
            if ({busy, mem_valid, mem_write_enable} !== {phase != 0, phase == 1, phase == 1 && m_wr})
                $display("FAIL rand_status cyc %0d: got %b required %b", cyc,
                         {busy, mem_valid, mem_write_enable}, {phase != 0, phase == 1, phase == 1 && m_wr});
            else n_pass++;
            n_total++;
            if ({req0_ready, req1_ready, arb_timeout} !== {exp_rdy[0], exp_rdy[1], 1'b0})
                $display("FAIL rand_ready cyc %0d: got %b required %b", cyc,
                         {req0_ready, req1_ready, arb_timeout}, {exp_rdy[0], exp_rdy[1], 1'b0});
            else n_pass++;
            n_total++;
            if (req0_read_data !== exp_rd[0] || req1_read_data !== exp_rd[1])
                $display("FAIL rand_rdata cyc %0d: got %h %h required %h %h", cyc,
                         req0_read_data, req1_read_data, exp_rd[0], exp_rd[1]);
            else n_pass++;
            if (phase == 1) begin
                n_total++;
                if (mem_address !== m_ad || mem_write_data !== m_wd)
                    $display("FAIL rand_membus cyc %0d: got %h %h required %h %h", cyc,
                             mem_address, mem_write_data, m_ad, m_wd);
                else n_pass++;
            end
            for (int p = 0; p < 2; p++) begin
                if (exp_rdy[p]) pend[p] = 0;
                if (!pend[p] && $urandom_range(0, 2) == 0) begin
                    pend[p] = 1; wr[p] = 1'($urandom_range(0, 1));
                    ad[p] = $urandom; wd[p] = $urandom;
                end
            end
            req0_valid = pend[0]; req0_write = wr[0]; req0_address = ad[0]; req0_write_data = wd[0];
            req1_valid = pend[1]; req1_write = wr[1]; req1_address = ad[1]; req1_write_data = wd[1];
            rdat = $urandom;
            if (phase == 1) begin
                bcnt++;
                ack = (bcnt >= lat);
            end else begin
                ack = ($urandom_range(0, 5) == 0);
            end
            mem_ack = ack; mem_read_data = rdat;
            exp_rdy = '{1'b0, 1'b0};
            case (phase)
                0: if (pend[0] || pend[1]) begin
                    owner = (pend[0] && pend[1]) ? 1 - last : (pend[1] ? 1 : 0);
                    m_wr = wr[owner]; m_ad = ad[owner]; m_wd = wd[owner];
                    phase = 1; bcnt = 0; lat = $urandom_range(1, 3);
                end
                1: if (ack) begin
                    if (!m_wr) exp_rd[owner] = rdat;
                    last = owner; exp_rdy[owner] = 1; phase = 2;
                end
                default: phase = 0;
            endcase
            step();
        end
        clear_inputs();
        step(); step();
    endtask

    initial begin
        clear_inputs();
        exp_rd1 = '0;
        test_reset();
        test_single_read();
        test_simultaneous();
        test_write();
        test_spurious_and_drop();
        test_reset_busy();
`ifdef MEM_ARB_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
